// File: rtl/counter_pkg.sv
// Shared encodings for the modulo-N counter block: mode, direction and wrap-counter width.
package counter_pkg;
    localparam logic MODE_WRAP  = 1'b0;
    localparam logic MODE_SAT   = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam logic DIR_UP     = 1'b1;
    localparam int   WRAP_CNT_W = 8;
endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle step pulse.
// PRESCALE=1 builds no register; the step follows the enable directly.
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic i_clock,
    input  logic i_reset_async_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_step
);
    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("counter_prescaler: PRESCALE must be >= 1");
        end

        if (PRESCALE == 1) begin : g_bypass
            logic unused_pins;
            assign unused_pins = ^{i_clock, i_reset_async_n, i_clear};
            assign o_step = i_enable;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] phase;

            assign o_step = i_enable && (phase == LAST);

            // Phase only moves on enabled cycles, so a disabled stretch pauses it.
            always_ff @(posedge i_clock or negedge i_reset_async_n) begin
                if (!i_reset_async_n)  phase <= '0;
                else if (i_clear)      phase <= '0;
                else if (o_step)       phase <= '0;
                else if (i_enable)     phase <= phase + PW'(1);
            end
        end
    endgenerate
endmodule

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with wrap/saturate mode, clear, clamped load and terminal pulse.
// Optional wrap counter built only when COUNTER_MOD_N_WRAP_CNT_EN is defined.
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int WIDTH     = 7,
    parameter int MAX_VALUE = 99,
    parameter int PRESCALE  = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset_async_n,
    input  logic                  i_enable,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_load_value,
    input  logic                  i_mode,
    input  logic                  i_up,
    output logic [WIDTH-1:0]      o_value,
    output logic                  o_tc,
    output logic                  o_done,
    output logic [WRAP_CNT_W-1:0] o_wrap_count
);
    generate
        if (MAX_VALUE <= 0 || longint'(MAX_VALUE) >= (longint'(1) << WIDTH)) begin : g_bad_max
            $error("counter_mod_n: MAX_VALUE must be in 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

    logic step;
    logic at_top;
    logic at_bottom;
    logic wrap_event;

    // Load also restarts the prescaler phase.
    counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .i_clock         (i_clock),
        .i_reset_async_n (i_reset_async_n),
        .i_enable        (i_enable),
        .i_clear         (i_clear | i_load),
        .o_step          (step)
    );

    assign at_top     = (o_value == MAX_V);
    assign at_bottom  = (o_value == '0);
    assign wrap_event = !i_clear && !i_load && step && (i_mode == MODE_WRAP) &&
                        ((i_up == DIR_UP) ? at_top : at_bottom);

    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            o_value <= '0;
            o_tc    <= 1'b0;
        end else if (i_clear) begin
            o_value <= '0;
            o_tc    <= 1'b0;
        end else if (i_load) begin
            o_value <= (i_load_value > MAX_V) ? MAX_V : i_load_value;
            o_tc    <= 1'b0;
        end else begin
            o_tc <= wrap_event;
            if (step) begin
                if (i_up == DIR_UP) begin
                    if (!at_top)                 o_value <= o_value + WIDTH'(1);
                    else if (i_mode == MODE_WRAP) o_value <= '0;
                end else begin
                    if (!at_bottom)              o_value <= o_value - WIDTH'(1);
                    else if (i_mode == MODE_WRAP) o_value <= MAX_V;
                end
            end
        end
    end

    assign o_done = (i_mode == MODE_SAT) && ((i_up == DIR_UP) ? at_top : at_bottom);

`ifdef COUNTER_MOD_N_WRAP_CNT_EN
    // Counts on the same edge that raises o_tc, so both are visible together.
    logic [WRAP_CNT_W-1:0] wrap_cnt;

    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n)
            wrap_cnt <= '0;
        else if (i_clear)
            wrap_cnt <= '0;
        else if (wrap_event && (wrap_cnt != {WRAP_CNT_W{1'b1}}))
            wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
    end

    assign o_wrap_count = wrap_cnt;
`else
    assign o_wrap_count = '0;
`endif
endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n: default instance plus a PRESCALE=4 instance, checked against a
// reference model through per-edge scoreboards and directed checks.
module tb_counter_mod_n;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, ld, mode, up;
    logic [6:0] ld_val;

    logic [6:0] v1, v2;
    logic       tc1, tc2, done1, done2;
    logic [7:0] wc1, wc2;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [6:0] val;
        logic [1:0] ps;
        logic       tc;
        logic [7:0] wc;
    } mstate_t;

    mstate_t s1, s2;
    mstate_t q1[$];
    mstate_t q2[$];

    always #5 clk = ~clk;

    counter_mod_n u_d1 (
        .i_clock(clk), .i_reset_async_n(rst_n), .i_enable(en), .i_clear(clr),
        .i_load(ld), .i_load_value(ld_val), .i_mode(mode), .i_up(up),
        .o_value(v1), .o_tc(tc1), .o_done(done1), .o_wrap_count(wc1)
    );

    counter_mod_n #(.WIDTH(7), .MAX_VALUE(99), .PRESCALE(4)) u_d2 (
        .i_clock(clk), .i_reset_async_n(rst_n), .i_enable(en), .i_clear(clr),
        .i_load(ld), .i_load_value(ld_val), .i_mode(mode), .i_up(up),
        .o_value(v2), .o_tc(tc2), .o_done(done2), .o_wrap_count(wc2)
    );

    function automatic logic [7:0] wc_exp(input int n);
`ifdef COUNTER_MOD_N_WRAP_CNT_EN
        return 8'(n);
`else
        return 8'(n * 0);
`endif
    endfunction

    // Reference behaviour for one clock edge, range 0..99.
    function automatic mstate_t nxt(input mstate_t s, input int presc);
        mstate_t n = s;
        n.tc = 1'b0;
        if (clr) begin
            n.val = 0; n.ps = 0; n.wc = 0;
        end else if (ld) begin
            n.val = (ld_val > 7'd99) ? 7'd99 : ld_val;
            n.ps  = 0;
        end else if (en) begin
            if (int'(s.ps) != presc - 1) n.ps = s.ps + 2'd1;
            else begin
                n.ps = 0;
                if (up) begin
                    if (s.val != 7'd99) n.val = s.val + 7'd1;
                    else if (!mode) begin n.val = 0; n.tc = 1'b1; end
                end else begin
                    if (s.val != 7'd0) n.val = s.val - 7'd1;
                    else if (!mode) begin n.val = 7'd99; n.tc = 1'b1; end
                end
            end
        end
`ifdef COUNTER_MOD_N_WRAP_CNT_EN
        if (n.tc && s.wc != 8'd255) n.wc = s.wc + 8'd1;
`else
        n.wc = 0;
`endif
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input mstate_t e, input logic [6:0] v,
                           input logic tc, input logic done, input logic [7:0] wc);
        logic edone;
        edone = mode & (up ? (e.val == 7'd99) : (e.val == 7'd0));
        chk({tag, ".value"}, 32'(v),    32'(e.val));
        chk({tag, ".tc"},    32'(tc),   32'(e.tc));
        chk({tag, ".done"},  32'(done), 32'(edone));
        chk({tag, ".wrap"},  32'(wc),   32'(e.wc));
    endtask

    // Drive is already settled; predict, clock, then score both instances.
    task automatic tick();
        mstate_t e;
        s1 = nxt(s1, 1);
        s2 = nxt(s2, 4);
        q1.push_back(s1);
        q2.push_back(s2);
        @(posedge clk);
        #1;
        e = q1.pop_front();
        chk_dut("d1", e, v1, tc1, done1, wc1);
        e = q2.pop_front();
        chk_dut("d2", e, v2, tc2, done2, wc2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic tc_seen;
        int   wraps;
        rst_n = 1'b0; en = 0; clr = 0; ld = 0; ld_val = 0; mode = 1'b1; up = 1'b0;
        s1 = '0; s2 = '0;
        @(posedge clk); #1;
        chk("rst.value", 32'(v1), 0);
        chk("rst.tc",    32'(tc1), 0);
        chk("rst.done",  32'(done1), 1);
        chk("rst.wrap",  32'(wc1), 0);
        up = 1'b1;
        #1 chk("done.dir_change", 32'(done1), 0);
        rst_n = 1'b1;

        // 1: wrap up
        mode = 1'b0; up = 1'b1; en = 1'b1;
        for (int i = 1; i <= 101; i++) begin
            tick();
            if (i == 99)  chk("t1.e99", 32'(v1), 99);
            if (i == 100) begin chk("t1.e100.v", 32'(v1), 0); chk("t1.e100.tc", 32'(tc1), 1); end
            if (i == 101) begin chk("t1.e101.v", 32'(v1), 1); chk("t1.e101.tc", 32'(tc1), 0); end
        end
        chk("t1.wrap", 32'(wc1), 32'(wc_exp(1)));

        // 2: saturate up
        clr = 1'b1; tick(); clr = 1'b0;
        mode = 1'b1; tc_seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            tc_seen |= tc1;
        end
        chk("t2.value", 32'(v1), 99);
        chk("t2.done",  32'(done1), 1);
        chk("t2.no_tc", 32'(tc_seen), 0);

        // 3: down wrap
        mode = 1'b0; ld = 1'b1; ld_val = 7'd2; tick(); ld = 1'b0;
        up = 1'b0;
        tick(); chk("t3.e1", 32'(v1), 1);  chk("t3.e1.tc", 32'(tc1), 0);
        tick(); chk("t3.e2", 32'(v1), 0);  chk("t3.e2.tc", 32'(tc1), 0);
        tick(); chk("t3.e3", 32'(v1), 99); chk("t3.e3.tc", 32'(tc1), 1);

        // 4: load clamp, priority, hold
        up = 1'b1;
        ld = 1'b1; ld_val = 7'd120; tick(); chk("t4.clamp", 32'(v1), 99);
        ld_val = 7'd50; tick(); ld = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t4.hold", 32'(v1), 50);
        en = 1'b1; clr = 1'b1; ld = 1'b1; ld_val = 7'd50; tick();
        chk("t4.prio", 32'(v1), 0);
        clr = 1'b0; ld = 1'b0;

        // 5: async reset mid-count
        for (int i = 0; i < 37; i++) tick();
        chk("t5.pre", 32'(v1), 37);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.async.v",  32'(v1), 0);
        chk("t5.async.tc", 32'(tc1), 0);
        chk("t5.async.v2", 32'(v2), 0);
        s1 = '0; s2 = '0;
        #1 rst_n = 1'b1;
        tick();
        chk("t5.first", 32'(v1), 1);

        // 6: prescale by 4
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("t6.div", 32'(v2), 10);
        tick(); tick();
        en = 1'b0; tick(); tick(); tick();
        chk("t6.pause", 32'(v2), 10);
        en = 1'b1; tick();
        chk("t6.phase_kept", 32'(v2), 10);
        tick();
        chk("t6.resume", 32'(v2), 11);
        wraps = 0;
        for (int i = 0; i < 2000 && wraps < 3; i++) begin
            tick();
            if (tc2 === 1'b1) wraps++;
        end
        chk("t6.wraps_reached", 32'(wraps), 3);
        chk("t6.wrap_count", 32'(wc2), 32'(wc_exp(3)));
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t6.clr.wrap",  32'(wc2), 0);
        chk("t6.clr.value", 32'(v2), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
